// File: rtl/fifo_uart_dumper.sv
// ============================================================================
// Module   : fifo_uart_dumper
// Purpose  : Reader end of the target-to-host record FIFO. A dump request
//            pops 16-bit records into a local frame buffer, then streams each
//            frame to the UART byte interface as:
//              SYNC_BYTE, [SEQ], LEN, {MSB, LSB} x LEN, CHK
//            CHK is the 8-bit sum of every byte after SYNC_BYTE.
//            A dump ends on the first frame that holds fewer than
//            MAX_FRAME_WORDS records. If the last frame is full, an empty
//            frame follows to end the dump.
// Ports    : clk, reset (async, active-low)
//            i_dump_start / o_busy / o_done / o_word_count - control/status
//            i_fifo_empty, o_fifo_ready_for_output (pop),
//            i_fifo_output_valid, i_fifo_output_data - upstream FIFO
//            o_write_strobe, o_write_data, i_tx_ready - UART byte transmit
// Config   : FIFO_UART_DUMPER_SEQ_EN - when defined, a per-dump frame
//            sequence byte follows SYNC_BYTE and is included in CHK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_dumper #(
  parameter int         NUM_ELEMENTS    = 4096,
  parameter int         MAX_FRAME_WORDS = 16,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_dump_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [$clog2(NUM_ELEMENTS):0]   o_word_count,
  input  logic                            i_fifo_empty,
  output logic                            o_fifo_ready_for_output,
  input  logic                            i_fifo_output_valid,
  input  logic [15:0]                     i_fifo_output_data,
  output logic                            o_write_strobe,
  output logic [7:0]                      o_write_data,
  input  logic                            i_tx_ready
);

  localparam int         c_wcw       = $clog2(NUM_ELEMENTS) + 1;
  localparam int         c_aw        = (MAX_FRAME_WORDS > 1) ? $clog2(MAX_FRAME_WORDS) : 1;
  localparam logic [7:0] c_max_words = 8'(MAX_FRAME_WORDS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FILL_REQ  = 4'd1,
    S_FILL_WAIT = 4'd2,
    S_SEND_SYNC = 4'd3,
    S_SEND_SEQ  = 4'd4,
    S_SEND_LEN  = 4'd5,
    S_SEND_HI   = 4'd6,
    S_SEND_LO   = 4'd7,
    S_SEND_CHK  = 4'd8,
    S_TX_GAP    = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  // SEND_* state to resume in once the one-cycle gap after a strobe is over
  state_t            r_ret;
  state_t            w_ret_next;
  logic [7:0]        r_n;          // records held in the frame buffer
  logic [7:0]        r_idx;        // record currently being transmitted
  logic [7:0]        r_chk;
  logic [c_wcw-1:0]  r_word_count;
  logic [15:0]       r_buf [MAX_FRAME_WORDS];
  logic [15:0]       w_word;
  logic              w_is_send;
  logic              w_pop;
  logic              w_strobe;
  logic [7:0]        w_byte;
  logic              w_accept;
`ifdef FIFO_UART_DUMPER_SEQ_EN
  logic [7:0]        r_seq;
`endif

  assign w_word   = r_buf[r_idx[c_aw-1:0]];
  assign w_accept = (r_state == S_FILL_WAIT) && i_fifo_output_valid;

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret;
    w_is_send    = 1'b0;
    w_pop        = 1'b0;
    w_strobe     = 1'b0;
    w_byte       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_dump_start) w_state_next = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        if (i_fifo_empty || (r_n == c_max_words)) begin
          w_state_next = S_SEND_SYNC;
        end else begin
          w_pop        = 1'b1;
          w_state_next = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (i_fifo_output_valid) w_state_next = S_FILL_REQ;
      end
      S_SEND_SYNC: begin
        w_is_send = 1'b1;
        w_byte    = SYNC_BYTE;
`ifdef FIFO_UART_DUMPER_SEQ_EN
        w_ret_next = S_SEND_SEQ;
`else
        w_ret_next = S_SEND_LEN;
`endif
      end
`ifdef FIFO_UART_DUMPER_SEQ_EN
      S_SEND_SEQ: begin
        w_is_send  = 1'b1;
        w_byte     = r_seq;
        w_ret_next = S_SEND_LEN;
      end
`endif
      S_SEND_LEN: begin
        w_is_send  = 1'b1;
        w_byte     = r_n;
        w_ret_next = (r_n == 8'd0) ? S_SEND_CHK : S_SEND_HI;
      end
      S_SEND_HI: begin
        w_is_send  = 1'b1;
        w_byte     = w_word[15:8];
        w_ret_next = S_SEND_LO;
      end
      S_SEND_LO: begin
        w_is_send  = 1'b1;
        w_byte     = w_word[7:0];
        w_ret_next = ((r_idx + 8'd1) == r_n) ? S_SEND_CHK : S_SEND_HI;
      end
      S_SEND_CHK: begin
        w_is_send  = 1'b1;
        w_byte     = r_chk;
        // A full frame means more records may be waiting upstream
        w_ret_next = (r_n == c_max_words) ? S_FILL_REQ : S_DONE;
      end
      S_TX_GAP: begin
        w_state_next = r_ret;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_is_send && i_tx_ready) begin
      w_strobe     = 1'b1;
      w_state_next = S_TX_GAP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ret        <= S_IDLE;
      r_n          <= 8'd0;
      r_idx        <= 8'd0;
      r_chk        <= 8'd0;
      r_word_count <= '0;
`ifdef FIFO_UART_DUMPER_SEQ_EN
      r_seq        <= 8'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_ret   <= w_ret_next;
      if ((r_state == S_IDLE) && i_dump_start) begin
        r_word_count <= '0;
        r_n          <= 8'd0;
`ifdef FIFO_UART_DUMPER_SEQ_EN
        r_seq        <= 8'd0;
`endif
      end
      if (w_accept) begin
        r_n <= r_n + 8'd1;
        if (r_word_count != {c_wcw{1'b1}}) r_word_count <= r_word_count + 1'b1;
      end
      if (w_strobe) begin
        case (r_state)
          S_SEND_SYNC: begin
            r_chk <= 8'd0;
            r_idx <= 8'd0;
          end
          S_SEND_LO: begin
            r_idx <= r_idx + 8'd1;
            r_chk <= r_chk + w_byte;
          end
          S_SEND_CHK: begin
            if (r_n == c_max_words) r_n <= 8'd0;
`ifdef FIFO_UART_DUMPER_SEQ_EN
            r_seq <= r_seq + 8'd1;
`endif
          end
          default: begin
            r_chk <= r_chk + w_byte;
          end
        endcase
      end
    end
  end

  // Frame buffer storage carries no reset; occupancy is tracked by r_n
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_n[c_aw-1:0]] <= i_fifo_output_data;
  end

  assign o_busy                  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done                  = (r_state == S_DONE);
  assign o_word_count            = r_word_count;
  assign o_fifo_ready_for_output = w_pop;
  assign o_write_strobe          = w_strobe;
  assign o_write_data            = w_strobe ? w_byte : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_dumper.sv
// ============================================================================
// Module   : tb_fifo_uart_dumper
// Purpose  : Self-checking bench for fifo_uart_dumper. An upstream FIFO model
//            with configurable pop latency and a UART sink with optional
//            random back-pressure surround the DUT. Expected byte streams are
//            built from the frame rules with plain queue arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_dumper;

  localparam int MAXW = 16;
`ifdef FIFO_UART_DUMPER_SEQ_EN
  localparam int HI_POS = 3;
`else
  localparam int HI_POS = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [12:0] word_count;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        fifo_valid;
  logic [15:0] fifo_data;
  logic        strobe;
  logic [7:0]  wdata;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  logic [15:0] fifo_q[$];
  int          fifo_len = 0;
  int          rd_ptr;
  int          vis_ptr;
  int          pop_lat = 1;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] dump_words[$];
  int          rx_base;
  bit          tx_rand = 1'b0;
  int          stall_at = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (vis_ptr >= fifo_len);

  fifo_uart_dumper #(
    .NUM_ELEMENTS    (4096),
    .MAX_FRAME_WORDS (MAXW),
    .SYNC_BYTE       (8'hA5)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .i_dump_start            (start),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_word_count            (word_count),
    .i_fifo_empty            (fifo_empty),
    .o_fifo_ready_for_output (fifo_pop),
    .i_fifo_output_valid     (fifo_valid),
    .i_fifo_output_data      (fifo_data),
    .o_write_strobe          (strobe),
    .o_write_data            (wdata),
    .i_tx_ready              (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: a pop seen in one cycle returns its word pop_lat cycles
  // later; the empty flag only reflects the pop after the following edge.
  initial begin
    logic [15:0] w;
    fifo_valid = 1'b0;
    fifo_data  = 16'h0000;
    rd_ptr     = 0;
    vis_ptr    = 0;
    forever begin
      @(negedge clk);
      if (reset && fifo_pop) begin
        check("pop_nonempty", 32'(rd_ptr < fifo_len), 32'd1);
        w = fifo_q[rd_ptr];
        rd_ptr++;
        for (int i = 1; i <= pop_lat; i++) begin
          @(posedge clk); #1;
          if (i == 1) vis_ptr = rd_ptr;
        end
        fifo_valid = 1'b1;
        fifo_data  = w;
        @(posedge clk); #1;
        fifo_valid = 1'b0;
        fifo_data  = 16'($urandom);
      end
    end
  end

  // UART sink ready: constant, random, or a 50-cycle stall after byte stall_at
  initial begin
    int stall_cnt = 0;
    int serviced  = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_at > 0 && rx_q.size() == stall_at && serviced != stall_at) begin
        stall_cnt = 50;
        serviced  = stall_at;
      end
      if (stall_cnt > 0) begin
        tx_ready = 1'b0;
        stall_cnt--;
      end else begin
        tx_ready = tx_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Byte monitor
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (strobe) begin
        check("strobe_needs_tx_ready", 32'(tx_ready), 32'd1);
        check("strobe_not_adjacent", 32'(prev), 32'd0);
        rx_q.push_back(wdata);
      end
      prev = strobe;
    end
  end

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(16'($urandom));
    fifo_len = fifo_q.size();
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_len = fifo_q.size();
  endtask

  task automatic build_expected();
    int         pos   = 0;
    int         frame = 0;
    int         len;
    logic [7:0] chk;
    exp_q.delete();
    do begin
      len = dump_words.size() - pos;
      if (len > MAXW) len = MAXW;
      chk = 8'h00;
      exp_q.push_back(8'hA5);
`ifdef FIFO_UART_DUMPER_SEQ_EN
      exp_q.push_back(8'(frame % 256));
      chk = chk + 8'(frame % 256);
`endif
      exp_q.push_back(8'(len));
      chk = chk + 8'(len);
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(dump_words[pos + i][15:8]);
        exp_q.push_back(dump_words[pos + i][7:0]);
        chk = chk + dump_words[pos + i][15:8] + dump_words[pos + i][7:0];
      end
      exp_q.push_back(chk);
      pos += len;
      frame++;
    end while (len == MAXW);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_dump(input string tag);
    bit seen = 1'b0;
    int f0;
    dump_words.delete();
    for (int i = rd_ptr; i < fifo_len; i++) dump_words.push_back(fifo_q[i]);
    build_expected();
    rx_base = rx_q.size();
    pulse_start();
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    // A second request while busy must be ignored
    pulse_start();
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_count"}, 32'(word_count), 32'(dump_words.size()));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_count_hold"}, 32'(word_count), 32'(dump_words.size()));
    check({tag, "_nbytes"}, 32'(rx_q.size() - rx_base), 32'(exp_q.size()));
    f0 = failures;
    for (int i = 0; i < exp_q.size() && (rx_base + i) < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_q[i]));
      if (failures != f0) break;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   32'(busy),       32'd0);
    check({tag, "_done"},   32'(done),       32'd0);
    check({tag, "_count"},  32'(word_count), 32'd0);
    check({tag, "_pop"},    32'(fifo_pop),   32'd0);
    check({tag, "_strobe"}, 32'(strobe),     32'd0);
    check({tag, "_data"},   32'(wdata),      32'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_dump("empty");

    push_word(16'h1234);
    push_word(16'hABCD);
    push_word(16'h0001);
    run_dump("three");

    push_random(MAXW);
    run_dump("exact16");

    pop_lat  = 5;
    push_random(5);
    stall_at = rx_q.size() + 4;
    run_dump("stall_lat5");
    stall_at = 0;

    for (int k = 0; k < 4; k++) begin
      pop_lat = $urandom_range(1, 6);
      tx_rand = 1'b1;
      push_random($urandom_range(0, 40));
      run_dump($sformatf("rand%0d", k));
    end
    tx_rand = 1'b0;
    pop_lat = 1;

    push_random(20);
    run_dump("seq20");

    // Reset while the first record's MSB is being strobed
    push_random(20);
    rx_base = rx_q.size();
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 5000 && cnt < HI_POS + 1; c++) begin
      @(posedge clk); #2;
      if (strobe) cnt++;
    end
    check("midreset_reached_hi", 32'(cnt), 32'(HI_POS + 1));
    reset = 1'b0;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    run_dump("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
